game_display_scan: RTL and testbench
====================================

# game_display_scan

Time-multiplexed 8-digit seven-segment display driver downstream of the game logic core. Takes the move count (BCD `ones`/`tens`), `gameState` and `gameDifficulty` and produces registered, scanned segment and digit-select outputs. Digits 7..4 show a status word, digit 3 shows difficulty, and digits 1..0 show the move count. Win/lose screens blink. Inputs are snapshotted once per frame so that each frame is internally consistent.

## Interface
- `SCAN_DIV`, default 1: clock cycles per digit slot (1 → 1 ms/digit at 1 kHz); legal range 1..255.
- `BLINK_HALF`, default 250: clock cycles per blink half-period (on or off); legal range 1..1023.
- `clk_1kHz` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `ones` in 4: move count, BCD units digit.
- `tens` in 4: move count, BCD tens digit.
- `gameState` in 2: 0 = lose, 1 = win, 2 = playing, 3 = undefined.
- `gameDifficulty` in 2: difficulty level 0..3.
- `seg` out 8: segment pattern, active-high; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
- `dig_sel` out 8: one-hot digit select, active-low; bit n enables digit n.

## Operation
- **Scan.**
  - The 8-bit prescaler counts 0..SCAN_DIV-1.
  - On terminal count it wraps to 0 and the 3-bit slot index advances by 1; 7 wraps to 0.
- **Snapshot.**
  - When the slot index wraps from 7 to 0, `ones`, `tens`, `gameState` and `gameDifficulty` are latched into shadow registers.
  - All decoding uses the shadow registers only.
  - Input changes mid-frame are never visible until the next frame.
- **Slot contents** (shadow values), by digit:
  - 7..4, status word:
    - state 2 → P, L, A, Y.
    - state 1 → P, A, S, S.
    - state 0 → F, A, I, L.
    - state 3 → all dashes.
  - 3: difficulty+1 (glyph 1..4), with dp lit.
  - 2: blank.
  - 1: `tens`.
  - 0: `ones`.
- **Glyph codes:**
  - Digits: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Letters: P=0x73, L=0x38, A=0x77, Y=0x6E, S=0x6D, F=0x71, I=0x06.
  - Other: dash=0x40, E=0x79, blank=0x00. Difficulty digit with dp = glyph | 0x80.
- **BCD out of range.** A `ones` or `tens` value of 10..15 displays E (0x79).
- **Blink.**
  - The 10-bit blink counter counts 0..BLINK_HALF-1; on terminal count it wraps and the blink phase toggles.
  - While shadow state is 0 or 1 and the phase is off: `dig_sel` = 0xFF and `seg` = 0x00.
  - While shadow state is 2 or 3: always displayed; the counter still runs.
- **Blink restart.** When the shadow state changes into 0 or 1 from any other value, the blink counter clears to 0 and the phase is forced on. The display therefore starts on a visible half-period.
- **Reset.** Reset overrides everything, including a simultaneous prescaler or blink wrap.

## Timing
- **Reset values:**
  - `seg` = 0x00, `dig_sel` = 0xFF.
  - Prescaler 0, slot index 0, blink counter 0, phase on.
  - Shadow registers: `ones` = 0, `tens` = 0, `gameState` = 2, `gameDifficulty` = 0.
- **Output latency.**
  - `seg` and `dig_sel` are registered: exactly 1 cycle after the slot index changes, the outputs reflect the new slot.
  - The first cycle after reset release still outputs 0xFF/0x00.
- **Output consistency.** `seg` and `dig_sel` always update on the same edge; no cycle ever shows a new digit select with an old pattern.
- **Snapshot latency.**
  - An input change becomes visible no later than 8×SCAN_DIV+1 cycles after it.
  - The snapshot is taken on the same edge as the 7→0 index wrap, so slot 0 of the new frame already uses the new values.
- **Blink restart latency.** The restart takes effect on the same edge as the shadow update.
- **Scan rate.** With SCAN_DIV = 1 every digit is lit for 1 cycle per 8-cycle frame.
- **Reset mid-frame.** Reset mid-frame restarts at slot 0 on the first cycle after `rst` deasserts.

## Configuration
- **`LEADING_ZERO_BLANK_EN`:**
  - Defined: when shadow `tens` == 0, digit 1 shows blank (0x00) instead of 0x3F.
  - Not defined: `tens` == 0 shows 0x3F.
  - Digit 0 is never blanked in either build.

## Test plan
- **Reset scan.** Reset, then run 16 cycles with SCAN_DIV = 1, inputs state 2, difficulty 0, count 00:
  - Cycle 1 after release: `dig_sel` = 0xFF, `seg` = 0x00.
  - Then per slot 0..7, with `dig_sel` = ~(1<<n): 0x3F, 0x3F, 0x00, 0x86, 0x6E, 0x77, 0x38, 0x73.
  - With `LEADING_ZERO_BLANK_EN` defined, slot 1 shows 0x00.
- **Mid-frame input change.** Change `ones` from 4 to 5 while slot 3 is active:
  - Slot 0 keeps 0x66 for the rest of the frame.
  - Slot 0 shows 0x6D from the next frame.
- **Win blink.** Set state 1 with BLINK_HALF = 4:
  - Status word P,A,S,S for 4 cycles after the shadow update.
  - Then 4 cycles of `dig_sel` = 0xFF / `seg` = 0x00, alternating thereafter.
  - Setting state back to 2 stops blinking by the next frame.
- **Lose and invalid values.** Set state 0, `tens` = 1, `ones` = 12, difficulty 3:
  - Slots show F,A,I,L; 0x06 on digit 1; 0x79 on digit 0; 0xE6 on digit 3.
- **Slower scan.** With SCAN_DIV = 3: each `dig_sel` value is held exactly 3 cycles and the frame is 24 cycles.
- **Reset mid-blink.** Assert reset during the off phase with a simultaneous blink wrap:
  - Next cycle `dig_sel` = 0xFF / `seg` = 0x00.
  - Shadow state reads 2.
  - After release the scan resumes at slot 0 with PLAY.

Source files
------------

// File: rtl/game_display_scan.sv
// game_display_scan
// Time-multiplexed 8-digit seven-segment driver for the game core.
//   digits 7..4 : status word (PLAY / PASS / FAIL / ----)
//   digit  3    : difficulty + 1, decimal point lit
//   digit  2    : blank
//   digits 1..0 : move count (BCD tens / ones), 10..15 shown as E
// Inputs are snapshotted into shadow registers on the 7->0 slot wrap so that
// every frame is internally consistent. Win/lose screens blink.
// seg is active-high {dp,g,f,e,d,c,b,a}; dig_sel is one-hot active-low.
//
// Build option:
//   LEADING_ZERO_BLANK_EN - when defined, a tens digit of 0 is shown blank.

module game_display_scan #(
  parameter int SCAN_DIV   = 1,    // clocks per digit slot, 1..255
  parameter int BLINK_HALF = 250   // clocks per blink half-period, 1..1023
) (
  input  logic       clk_1kHz,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] gameState,
  input  logic [1:0] gameDifficulty,
  output logic [7:0] seg,
  output logic [7:0] dig_sel
);

  localparam logic [7:0] SCAN_LAST  = 8'(SCAN_DIV - 1);
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF - 1);

  localparam logic [1:0] ST_LOSE = 2'd0;
  localparam logic [1:0] ST_WIN  = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  localparam logic [7:0] GL_BLANK = 8'h00;
  localparam logic [7:0] GL_DASH  = 8'h40;
  localparam logic [7:0] GL_E     = 8'h79;
  localparam logic [7:0] GL_P     = 8'h73;
  localparam logic [7:0] GL_L     = 8'h38;
  localparam logic [7:0] GL_A     = 8'h77;
  localparam logic [7:0] GL_Y     = 8'h6E;
  localparam logic [7:0] GL_S     = 8'h6D;
  localparam logic [7:0] GL_F     = 8'h71;
  localparam logic [7:0] GL_I     = 8'h06;
  localparam logic [7:0] DP_BIT   = 8'h80;

  // BCD digit to segment pattern; out-of-range codes render as E.
  function automatic logic [7:0] digit_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'd0:    g = 8'h3F;
      4'd1:    g = 8'h06;
      4'd2:    g = 8'h5B;
      4'd3:    g = 8'h4F;
      4'd4:    g = 8'h66;
      4'd5:    g = 8'h6D;
      4'd6:    g = 8'h7D;
      4'd7:    g = 8'h07;
      4'd8:    g = 8'h7F;
      4'd9:    g = 8'h6F;
      default: g = GL_E;
    endcase
    return g;
  endfunction

  // Win and lose are the two blinking screens.
  function automatic logic is_blink_state(input logic [1:0] st);
    return (st == ST_LOSE) || (st == ST_WIN);
  endfunction

  // Status-word letter; pos 3 is the leftmost digit (7), pos 0 is digit 4.
  function automatic logic [7:0] status_glyph(input logic [1:0] st,
                                              input logic [1:0] pos);
    logic [7:0] g;
    case (st)
      ST_PLAY: begin
        case (pos)
          2'd3:    g = GL_P;
          2'd2:    g = GL_L;
          2'd1:    g = GL_A;
          2'd0:    g = GL_Y;
          default: g = GL_DASH;
        endcase
      end
      ST_WIN: begin
        case (pos)
          2'd3:    g = GL_P;
          2'd2:    g = GL_A;
          2'd1:    g = GL_S;
          2'd0:    g = GL_S;
          default: g = GL_DASH;
        endcase
      end
      ST_LOSE: begin
        case (pos)
          2'd3:    g = GL_F;
          2'd2:    g = GL_A;
          2'd1:    g = GL_I;
          2'd0:    g = GL_L;
          default: g = GL_DASH;
        endcase
      end
      default: g = GL_DASH;
    endcase
    return g;
  endfunction

  logic [7:0] presc_r;
  logic [2:0] slot_r;
  logic [9:0] blink_cnt_r;
  logic       blink_on_r;
  logic [3:0] sh_ones_r;
  logic [3:0] sh_tens_r;
  logic [1:0] sh_state_r;
  logic [1:0] sh_diff_r;
  logic [7:0] seg_r;
  logic [7:0] dig_sel_r;

  logic       presc_wrap_s;
  logic       frame_wrap_s;
  logic       blink_wrap_s;
  logic       blink_restart_s;
  logic       blank_s;
  logic [7:0] glyph_s;
  logic [7:0] scan_sel_s;

  assign presc_wrap_s    = (presc_r == SCAN_LAST);
  assign frame_wrap_s    = presc_wrap_s && (slot_r == 3'd7);
  assign blink_wrap_s    = (blink_cnt_r == BLINK_LAST);
  // Entering win/lose from a different state restarts on a visible half.
  assign blink_restart_s = frame_wrap_s && is_blink_state(gameState) &&
                           (gameState != sh_state_r);
  assign blank_s         = is_blink_state(sh_state_r) && !blink_on_r;
  assign scan_sel_s      = ~(8'd1 << slot_r);

  // Prescaler and slot index: advance one digit every SCAN_DIV clocks.
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      presc_r <= 8'd0;
      slot_r  <= 3'd0;
    end else if (presc_wrap_s) begin
      presc_r <= 8'd0;
      slot_r  <= slot_r + 3'd1;
    end else begin
      presc_r <= presc_r + 8'd1;
      slot_r  <= slot_r;
    end
  end

  // Shadow registers: sample the game inputs once per frame on the 7->0 wrap.
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      sh_ones_r  <= 4'd0;
      sh_tens_r  <= 4'd0;
      sh_state_r <= ST_PLAY;
      sh_diff_r  <= 2'd0;
    end else if (frame_wrap_s) begin
      sh_ones_r  <= ones;
      sh_tens_r  <= tens;
      sh_state_r <= gameState;
      sh_diff_r  <= gameDifficulty;
    end else begin
      sh_ones_r  <= sh_ones_r;
      sh_tens_r  <= sh_tens_r;
      sh_state_r <= sh_state_r;
      sh_diff_r  <= sh_diff_r;
    end
  end

  // Blink timer: free-running half-period counter with a restart on entry.
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      blink_cnt_r <= 10'd0;
      blink_on_r  <= 1'b1;
    end else if (blink_restart_s) begin
      blink_cnt_r <= 10'd0;
      blink_on_r  <= 1'b1;
    end else if (blink_wrap_s) begin
      blink_cnt_r <= 10'd0;
      blink_on_r  <= ~blink_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 10'd1;
      blink_on_r  <= blink_on_r;
    end
  end

  // Slot decode: choose the glyph for the current slot from shadow values.
  always_comb begin
    glyph_s = GL_BLANK;
    case (slot_r)
      3'd0: glyph_s = digit_glyph(sh_ones_r);
      3'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (sh_tens_r == 4'd0) begin
          glyph_s = GL_BLANK;
        end else begin
          glyph_s = digit_glyph(sh_tens_r);
        end
`else
        glyph_s = digit_glyph(sh_tens_r);
`endif
      end
      3'd2: glyph_s = GL_BLANK;
      3'd3: glyph_s = digit_glyph({2'b00, sh_diff_r} + 4'd1) | DP_BIT;
      3'd4, 3'd5, 3'd6, 3'd7: glyph_s = status_glyph(sh_state_r, slot_r[1:0]);
      default: glyph_s = GL_BLANK;
    endcase
  end

  // Output stage: segment pattern and digit select always change together.
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      seg_r     <= GL_BLANK;
      dig_sel_r <= 8'hFF;
    end else if (blank_s) begin
      seg_r     <= GL_BLANK;
      dig_sel_r <= 8'hFF;
    end else begin
      seg_r     <= glyph_s;
      dig_sel_r <= scan_sel_s;
    end
  end

  assign seg     = seg_r;
  assign dig_sel = dig_sel_r;

endmodule

// File: tb/tb_game_display_scan.sv
// Testbench for game_display_scan.
// Two instances (SCAN_DIV=1/BLINK_HALF=4 and SCAN_DIV=3/BLINK_HALF=5) share
// the stimulus. The driver pushes the expected {dig_sel,seg} for every edge
// into a per-instance queue; a monitor pops and compares after each edge.
// Expected values come from a frame/time arithmetic model of the display.

module tb_game_display_scan;

  localparam int S1 = 1;
  localparam int B1 = 4;
  localparam int S3 = 3;
  localparam int B3 = 5;
  localparam int NMAX = 8192;

  logic       clk_1kHz = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ones = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [1:0] gameState = 2'd2;
  logic [1:0] gameDifficulty = 2'd0;
  logic [7:0] seg1, dig1, seg3, dig3;

  always #5 clk_1kHz = ~clk_1kHz;

  game_display_scan #(.SCAN_DIV(S1), .BLINK_HALF(B1)) dut1 (
    .clk_1kHz(clk_1kHz), .rst(rst), .ones(ones), .tens(tens),
    .gameState(gameState), .gameDifficulty(gameDifficulty),
    .seg(seg1), .dig_sel(dig1));

  game_display_scan #(.SCAN_DIV(S3), .BLINK_HALF(B3)) dut3 (
    .clk_1kHz(clk_1kHz), .rst(rst), .ones(ones), .tens(tens),
    .gameState(gameState), .gameDifficulty(gameDifficulty),
    .seg(seg3), .dig_sel(dig3));

  // Inputs present at edge n (counted from the last reset edge = 0).
  int on_a [NMAX];
  int tn_a [NMAX];
  int st_a [NMAX];
  int df_a [NMAX];
  int e_cnt = 0;

  logic [15:0] q1[$];
  logic [15:0] q3[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] dglyph(input int v);
    case (v)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      default: return 8'h79;
    endcase
  endfunction

  // Letter pos 0 is the leftmost status digit (digit 7).
  function automatic logic [7:0] status_letter(input int st, input int pos);
    logic [31:0] w;
    case (st)
      2: w = 32'h7338776E;       // P L A Y
      1: w = 32'h73776D6D;       // P A S S
      0: w = 32'h71770638;       // F A I L
      default: w = 32'h40404040;
    endcase
    return w[31 - 8*pos -: 8];
  endfunction

  // Latest edge (<= k) at which the snapshot moved the state into win/lose.
  function automatic int last_restart(input int k, input int s);
    int r = 0;
    int prev = 2;
    for (int g = 1; g * 8 * s <= k; g++) begin
      int cur = st_a[g * 8 * s];
      if ((cur == 0 || cur == 1) && cur != prev) r = g * 8 * s;
      prev = cur;
    end
    return r;
  endfunction

  // Expected {dig_sel, seg} visible just after edge e.
  function automatic logic [15:0] expect_out(input int e, input int s, input int b);
    int k, slot, f, so, te, st, df, r;
    bit on;
    logic [7:0] g;
    if (e == 0) return {8'hFF, 8'h00};
    k = e - 1;
    slot = (k / s) % 8;
    f = k / (8 * s);
    if (f == 0) begin
      so = 0; te = 0; st = 2; df = 0;
    end else begin
      so = on_a[f*8*s]; te = tn_a[f*8*s]; st = st_a[f*8*s]; df = df_a[f*8*s];
    end
    r = last_restart(k, s);
    on = (((k - r) / b) % 2) == 0;
    if ((st == 0 || st == 1) && !on) return {8'hFF, 8'h00};
    case (slot)
      0: g = dglyph(so);
`ifdef LEADING_ZERO_BLANK_EN
      1: g = (te == 0) ? 8'h00 : dglyph(te);
`else
      1: g = dglyph(te);
`endif
      2: g = 8'h00;
      3: g = dglyph(df + 1) | 8'h80;
      default: g = status_letter(st, 7 - slot);
    endcase
    return {~(8'd1 << slot), g};
  endfunction

  // True when the S1/B1 instance is blanked and its blink wraps on the next edge.
  function automatic bit at_off_wrap(input int e);
    int f, st, m;
    f = e / 8;
    if (f == 0) return 1'b0;
    st = st_a[f*8];
    if (!(st == 0 || st == 1)) return 1'b0;
    m = e - last_restart(e, S1);
    return (((m / B1) % 2) == 1) && ((m % B1) == B1 - 1);
  endfunction

  task automatic step(input logic r, input int o, input int t, input int s, input int d);
    @(negedge clk_1kHz);
    rst = r;
    ones = 4'(o);
    tens = 4'(t);
    gameState = 2'(s);
    gameDifficulty = 2'(d);
    if (r) begin
      e_cnt = 0;
    end else begin
      e_cnt++;
      on_a[e_cnt] = o; tn_a[e_cnt] = t; st_a[e_cnt] = s; df_a[e_cnt] = d;
    end
    q1.push_back(expect_out(e_cnt, S1, B1));
    q3.push_back(expect_out(e_cnt, S3, B3));
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Monitor: after each edge compare both instances against queued values.
  initial begin
    logic [15:0] x;
    forever begin
      @(posedge clk_1kHz);
      #1;
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check("dut1.dig_sel", dig1, x[15:8]);
        check("dut1.seg", seg1, x[7:0]);
      end
      if (q3.size() > 0) begin
        x = q3.pop_front();
        check("dut3.dig_sel", dig3, x[15:8]);
        check("dut3.seg", seg3, x[7:0]);
      end
    end
  end

  initial begin
    int o, t, s, d;
    bit found;
    // Reset then a plain PLAY frame with count 00.
    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 2, 0);
    for (int i = 0; i < 30; i++) step(1'b0, 0, 0, 2, 0);
    // Mid-frame change of ones 4 -> 5.
    for (int i = 0; i < 27; i++) step(1'b0, 4, 0, 2, 1);
    for (int i = 0; i < 30; i++) step(1'b0, 5, 0, 2, 1);
    // Win screen blinking, then back to play.
    for (int i = 0; i < 40; i++) step(1'b0, 7, 2, 1, 2);
    for (int i = 0; i < 30; i++) step(1'b0, 7, 2, 2, 2);
    // Lose with out-of-range ones and max difficulty.
    for (int i = 0; i < 50; i++) step(1'b0, 12, 1, 0, 3);
    // Win again, then reset on an off-phase edge coinciding with a blink wrap.
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1'b0, 3, 9, 1, 1);
      if (i > 10 && at_off_wrap(e_cnt)) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL reset_point: got none expected an off-phase wrap within 80 cycles");
    end
    step(1'b1, 3, 9, 1, 1);
    for (int i = 0; i < 30; i++) step(1'b0, 3, 9, 2, 1);
    // Randomized traffic with held inputs and occasional resets.
    o = 0; t = 0; s = 2; d = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        o = $urandom_range(0, 15);
        t = $urandom_range(0, 15);
        s = $urandom_range(0, 3);
        d = $urandom_range(0, 3);
      end
      step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, o, t, s, d);
    end
    @(posedge clk_1kHz);
    #3;
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d queued expected 0/0", q1.size(), q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
